cpu_sequencer: RTL and testbench

//  Multicycle control FSM for the 8-bit CPU. Fetches instructions, decodes them, drives the

---
 rtl/cpu_sequencer.sv | 147 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multicycle fetch/decode/execute/writeback sequencer for the 8-bit CPU.
// Drives the 4x8 register file ports and supports free-run and single-step operation.
module cpu_sequencer #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    input  logic              step_i,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic [7:0]        imem_data_i,
    output logic [1:0]        rf_rs_o,
    output logic [1:0]        rf_rt_o,
    output logic [1:0]        rf_rd_o,
    output logic              rf_we_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic [DATA_W-1:0] rf_rdata1_i,
    input  logic [DATA_W-1:0] rf_rdata2_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [7:0]        ir_o,
    output logic              busy_o,
    output logic              instr_done_o,
    output logic              halted_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDI = 2'b10;
    localparam logic [1:0] OP_JMP  = 2'b11;

    state_t              state_q;
    logic [PC_W-1:0]     pc_q;
    logic [7:0]          ir_q;
    logic                busy_q;
    logic                instr_done_q;
    logic                halted_q;
    logic                rf_we_q;
    logic [1:0]          rf_rd_q;
    logic [DATA_W-1:0]   rf_wdata_q;

    logic [1:0]          op;
    logic [DATA_W-1:0]   imm_ext;
    logic [PC_W-1:0]     jmp_off;
    logic [PC_W-1:0]     jmp_tgt;
    logic                is_halt;
    logic [DATA_W-1:0]   alu_res;

    assign op      = ir_q[7:6];
    assign imm_ext = {{(DATA_W-2){ir_q[1]}}, ir_q[1:0]};
    assign jmp_off = {{(PC_W-6){ir_q[5]}}, ir_q[5:0]};
    assign jmp_tgt = pc_q + jmp_off;
    // A jump to itself can never make progress, so it is the program's halt marker.
    assign is_halt = (op == OP_JMP) && (ir_q[5:0] == 6'd0);

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = rf_rdata1_i + rf_rdata2_i;
            OP_SUB:  alu_res = rf_rdata1_i - rf_rdata2_i;
            OP_ADDI: alu_res = rf_rdata1_i + imm_ext;
            default: alu_res = '0;
        endcase
    end

    // Async reset also clears rf_we_q, aborting any write in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            busy_q       <= 1'b0;
            instr_done_q <= 1'b0;
            halted_q     <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_wdata_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_i || step_i) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    ir_q    <= imem_data_i;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q      <= S_WB;
                    instr_done_q <= 1'b1;
                    if (op != OP_JMP) begin
                        rf_we_q    <= 1'b1;
                        rf_rd_q    <= (op == OP_ADDI) ? ir_q[3:2] : ir_q[1:0];
                        rf_wdata_q <= alu_res;
                    end
                end
                S_WB: begin
                    instr_done_q <= 1'b0;
                    rf_we_q      <= 1'b0;
                    rf_rd_q      <= '0;
                    rf_wdata_q   <= '0;
                    pc_q         <= (op == OP_JMP) ? jmp_tgt : pc_q + PC_W'(1);
                    if (is_halt) begin
                        state_q  <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (run_i) begin
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign ir_o         = ir_q;
    assign rf_rs_o      = ir_q[5:4];
    assign rf_rt_o      = ir_q[3:2];
    assign rf_rd_o      = rf_rd_q;
    assign rf_we_o      = rf_we_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign busy_o       = busy_q;
    assign instr_done_o = instr_done_q;
    assign halted_o     = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: ROM and register file models, plus an ISA reference model
// that pushes expected writebacks to a scoreboard popped on every instr_done pulse.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [1:0] rf_rs, rf_rt, rf_rd;
    logic       rf_we;
    logic [7:0] rf_wdata, rf_rdata1, rf_rdata2;
    logic [7:0] pc, ir;
    logic       busy, instr_done, halted;

    cpu_sequencer #(.PC_W(8), .DATA_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .run_i        (run),
        .step_i       (step),
        .imem_addr_o  (imem_addr),
        .imem_data_i  (imem_data),
        .rf_rs_o      (rf_rs),
        .rf_rt_o      (rf_rt),
        .rf_rd_o      (rf_rd),
        .rf_we_o      (rf_we),
        .rf_wdata_o   (rf_wdata),
        .rf_rdata1_i  (rf_rdata1),
        .rf_rdata2_i  (rf_rdata2),
        .pc_o         (pc),
        .ir_o         (ir),
        .busy_o       (busy),
        .instr_done_o (instr_done),
        .halted_o     (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [256];
    assign imem_data = rom[imem_addr];

    logic [7:0] regs     [4];
    logic [7:0] pre_vals [4];
    logic       pre_en = 1'b0;
    assign rf_rdata1 = regs[rf_rs];
    assign rf_rdata2 = regs[rf_rt];

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 4; i++) regs[i] <= pre_vals[i];
        end else if (rf_we) begin
            regs[rf_rd] <= rf_wdata;
        end
    end

    typedef struct packed {
        logic [7:0] pc;
        logic       we;
        logic [1:0] rd;
        logic [7:0] wd;
    } wb_t;

    wb_t        sb [$];
    wb_t        got_e;
    logic [7:0] ref_regs [4];
    logic [7:0] ref_pc;
    int         errors = 0;
    int         checks = 0;

    // Clock advance; any writeback seen is compared against the scoreboard head.
    task automatic tick();
        @(negedge clk);
        if (instr_done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: unexpected instr_done at pc=%h", pc);
            end else begin
                got_e = sb.pop_front();
                if ({pc, rf_we, rf_rd, rf_wdata} !== {got_e.pc, got_e.we, got_e.rd, got_e.wd}) begin
                    errors++;
                    $display("FAIL wb: got pc=%h we=%b rd=%0d wd=%h, expected pc=%h we=%b rd=%0d wd=%h",
                             pc, rf_we, rf_rd, rf_wdata, got_e.pc, got_e.we, got_e.rd, got_e.wd);
                end
            end
        end
    endtask

    task automatic model_run(input int n);
        logic [7:0] ins, a, b;
        wb_t e;
        for (int i = 0; i < n; i++) begin
            ins = rom[ref_pc];
            a = ref_regs[ins[5:4]];
            b = ref_regs[ins[3:2]];
            e.pc = ref_pc; e.we = 1'b0; e.rd = 2'd0; e.wd = 8'd0;
            case (ins[7:6])
                2'b00: begin e.we = 1'b1; e.rd = ins[1:0]; e.wd = a + b; end
                2'b01: begin e.we = 1'b1; e.rd = ins[1:0]; e.wd = a - b; end
                2'b10: begin e.we = 1'b1; e.rd = ins[3:2]; e.wd = a + {{6{ins[1]}}, ins[1:0]}; end
                default: ;
            endcase
            sb.push_back(e);
            if (e.we) ref_regs[e.rd] = e.wd;
            if (ins[7:6] == 2'b11) begin
                if (ins[5:0] == 6'd0) break;
                ref_pc = ref_pc + {{2{ins[5]}}, ins[5:0]};
            end else begin
                ref_pc = ref_pc + 8'd1;
            end
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset(input logic [7:0] r0, r1, r2, r3);
        sb.delete();
        reset = 1'b1; run = 1'b0; step = 1'b0;
        pre_vals[0] = r0; pre_vals[1] = r1; pre_vals[2] = r2; pre_vals[3] = r3;
        for (int i = 0; i < 4; i++) ref_regs[i] = pre_vals[i];
        ref_pc = 8'd0;
        pre_en = 1'b1;
        tick();
        tick();
        pre_en = 1'b0;
        reset = 1'b0;
    endtask

    task automatic wait_halt(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (halted === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (busy === 1'b0) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        do_reset(8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        checks++;
        if ({pc, ir, imem_addr} !== 24'd0) begin
            errors++; $display("FAIL reset_pc_ir: pc=%h ir=%h addr=%h, expected 0", pc, ir, imem_addr);
        end
        checks++;
        if ({rf_we, rf_rd, rf_wdata, rf_rs, rf_rt} !== 15'd0) begin
            errors++; $display("FAIL reset_rf: we=%b rd=%0d wd=%h rs=%0d rt=%0d, expected 0",
                               rf_we, rf_rd, rf_wdata, rf_rs, rf_rt);
        end
        checks++;
        if ({busy, instr_done, halted} !== 3'b000) begin
            errors++; $display("FAIL reset_status: busy=%b done=%b halted=%b, expected 000", busy, instr_done, halted);
        end
    endtask

    task automatic test_reset_mid_wb();
        bit found;
        clear_rom();
        rom[0] = 8'h06;
        do_reset(8'd5, 8'd3, 8'hAA, 8'd0);
        model_run(1);
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (instr_done === 1'b1) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || rf_we !== 1'b1) begin
            errors++; $display("FAIL midwb_reach: found=%b we=%b, expected WB with we=1", found, rf_we);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({rf_we, rf_rd, rf_wdata, instr_done, busy, pc, ir} !== 29'd0) begin
            errors++; $display("FAIL midwb_async: we=%b rd=%0d wd=%h done=%b busy=%b pc=%h ir=%h, expected 0",
                               rf_we, rf_rd, rf_wdata, instr_done, busy, pc, ir);
        end
        run = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (regs[2] !== 8'hAA || busy !== 1'b0) begin
            errors++; $display("FAIL midwb_nowrite: r2=%h busy=%b, expected r2=aa busy=0", regs[2], busy);
        end
    endtask

    task automatic test_add_run();
        int cyc;
        bit ok;
        clear_rom();
        rom[0] = 8'h06;
        rom[1] = 8'hC0;
        do_reset(8'd5, 8'd3, 8'd0, 8'd0);
        model_run(10);
        run = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL add_fetch_busy: busy=%b, expected 1", busy);
        end
        cyc = 1;
        while (instr_done !== 1'b1 && cyc < 8) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 4) begin
            errors++; $display("FAIL add_latency: done in cycle %0d, expected 4", cyc);
        end
        checks++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 2'd2, 8'd8}) begin
            errors++; $display("FAIL add_wb: we=%b rd=%0d wd=%h, expected we=1 rd=2 wd=08", rf_we, rf_rd, rf_wdata);
        end
        wait_halt(40, ok);
        checks++;
        if (!ok || regs[2] !== 8'd8) begin
            errors++; $display("FAIL add_result: halted=%b r2=%h, expected halted r2=08", ok, regs[2]);
        end
        run = 1'b0;
    endtask

    task automatic test_alu();
        bit ok;
        clear_rom();
        rom[0] = 8'h46;
        rom[1] = 8'h9E;
        rom[2] = 8'h2C;
        rom[3] = 8'hC0;
        do_reset(8'd3, 8'd5, 8'd0, 8'd0);
        model_run(10);
        run = 1'b1;
        wait_halt(60, ok);
        run = 1'b0;
        checks++;
        if (!ok || {regs[0], regs[2], regs[3], pc} !== {8'h01, 8'hFE, 8'h03, 8'h03}) begin
            errors++; $display("FAIL alu_regs: halted=%b r0=%h r2=%h r3=%h pc=%h, expected r0=01 r2=fe r3=03 pc=03",
                               ok, regs[0], regs[2], regs[3], pc);
        end
    endtask

    task automatic test_jmp_wrap();
        bit ok;
        logic [7:0] exp_pc [4];
        exp_pc[0] = 8'h02; exp_pc[1] = 8'hFE; exp_pc[2] = 8'hFF; exp_pc[3] = 8'h00;
        clear_rom();
        rom[8'h00] = 8'hC2;
        rom[8'h02] = 8'hFC;
        rom[8'hFE] = 8'h95;
        rom[8'hFF] = 8'h06;
        do_reset(8'd5, 8'd3, 8'd0, 8'd0);
        model_run(4);
        for (int s = 0; s < 4; s++) begin
            pulse_step();
            wait_idle(20, ok);
            checks++;
            if (!ok || pc !== exp_pc[s]) begin
                errors++; $display("FAIL jmp_pc_step%0d: idle=%b pc=%h, expected %h", s, ok, pc, exp_pc[s]);
            end
        end
        checks++;
        if (regs[1] !== 8'd4 || regs[2] !== 8'd9) begin
            errors++; $display("FAIL jmp_regs: r1=%h r2=%h, expected 04 09", regs[1], regs[2]);
        end
    endtask

    task automatic test_halt();
        bit ok;
        int dones;
        clear_rom();
        rom[0] = 8'h95;
        rom[1] = 8'hC0;
        do_reset(8'd0, 8'd7, 8'd0, 8'd0);
        model_run(10);
        run = 1'b1;
        wait_halt(40, ok);
        checks++;
        if (!ok || busy !== 1'b0 || pc !== 8'h01 || ir !== 8'hC0) begin
            errors++; $display("FAIL halt_enter: halted=%b busy=%b pc=%h ir=%h, expected 1 0 01 c0", ok, busy, pc, ir);
        end
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            run  = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            tick();
            if (instr_done === 1'b1) dones++;
        end
        run = 1'b0; step = 1'b0;
        checks++;
        if (dones != 0 || halted !== 1'b1 || busy !== 1'b0 || pc !== 8'h01 || ir !== 8'hC0) begin
            errors++; $display("FAIL halt_hold: dones=%0d halted=%b busy=%b pc=%h ir=%h, expected 0 1 0 01 c0",
                               dones, halted, busy, pc, ir);
        end
    endtask

    task automatic test_step();
        int cnt;
        clear_rom();
        for (int i = 0; i < 4; i++) rom[i] = 8'h95;
        do_reset(8'd0, 8'd0, 8'd0, 8'd0);
        model_run(3);
        pulse_step();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (instr_done === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 1 || busy !== 1'b0 || pc !== 8'd1) begin
            errors++; $display("FAIL step_single: dones=%0d busy=%b pc=%h, expected 1 0 01", cnt, busy, pc);
        end
        pulse_step();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (instr_done === 1'b1) cnt++;
            step = (i == 1);
        end
        step = 1'b0;
        checks++;
        if (cnt != 1 || busy !== 1'b0 || pc !== 8'd2) begin
            errors++; $display("FAIL step_in_exec: dones=%0d busy=%b pc=%h, expected 1 0 02", cnt, busy, pc);
        end
        run = 1'b1;
        tick();
        tick();
        run = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (instr_done === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 1 || busy !== 1'b0 || pc !== 8'd3 || regs[1] !== 8'd3) begin
            errors++; $display("FAIL run_drop: dones=%0d busy=%b pc=%h r1=%h, expected 1 0 03 03",
                               cnt, busy, pc, regs[1]);
        end
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        test_reset();
        test_reset_mid_wb();
        test_add_run();
        test_alu();
        test_jmp_wrap();
        test_halt();
        test_step();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover: %0d writebacks never seen, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
